// File: rtl/qed_pkg.sv
// Opcodes, state encoding and the duplicate register-remap transform shared by the QED duplicate scheduler.
// The optional unsupported-opcode filter is enabled by defining QED_UNSUPPORTED_CHECK_EN.
package qed_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_R32   = 7'b0111011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_I32   = 7'b0011011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ORIG = 2'd1;
    localparam logic [1:0] ST_DUP  = 2'd2;

    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;

    function automatic logic qed_is_supported(input logic [6:0] op);
        logic ok;
        case (op)
            OP_R, OP_R32, OP_I, OP_I32, OP_LOAD,
            OP_STORE, OP_LUI, OP_AUIPC: ok = 1'b1;
            default:                    ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Setting the MSB of a nonzero register field moves x1-x15 into x17-x31; x0 must stay x0.
    function automatic logic [31:0] qed_transform(input logic [31:0] instr);
        logic [31:0] t;
        logic        use_rd;
        logic        use_rs1;
        logic        use_rs2;
        t = instr;
        case (instr[6:0])
            OP_R, OP_R32:           {use_rd, use_rs1, use_rs2} = 3'b111;
            OP_I, OP_I32, OP_LOAD:  {use_rd, use_rs1, use_rs2} = 3'b110;
            OP_STORE:               {use_rd, use_rs1, use_rs2} = 3'b011;
            OP_LUI, OP_AUIPC:       {use_rd, use_rs1, use_rs2} = 3'b100;
            default:                {use_rd, use_rs1, use_rs2} = 3'b000;
        endcase
        if (use_rd)  t[RD_MSB]  = t[RD_MSB]  | (|instr[RD_MSB:RD_LSB]);
        if (use_rs1) t[RS1_MSB] = t[RS1_MSB] | (|instr[RS1_MSB:RS1_LSB]);
        if (use_rs2) t[RS2_MSB] = t[RS2_MSB] | (|instr[RS2_MSB:RS2_LSB]);
        return t;
    endfunction

endpackage

// File: rtl/qed_dup_fifo.sv
// Circular DEPTH x 32 instruction buffer; pointers carry one extra wrap bit so full and empty
// are distinguished by their MSBs.
module qed_dup_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [31:0]            i_data,
    input  logic                   i_pop,
    output logic [31:0]            o_head,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [31:0] r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    assign w_do_push = i_push & ~o_full & ~i_flush;
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/qed_dup_scheduler.sv
// Records original instructions, replays them as register-remapped duplicates, and counts both streams.
// Define QED_UNSUPPORTED_CHECK_EN to filter (and flag) opcodes the transform does not handle.
module qed_dup_scheduler
    import qed_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ena,
    input  logic             i_stall,
    input  logic             i_qic_valid,
    input  logic [31:0]      i_qic_instruction,
    input  logic             i_exec_dup_req,
    output logic [31:0]      o_qed_instruction,
    output logic             o_exec_dup,
    output logic             o_qed_ready,
    output logic [CNT_W-1:0] o_num_orig,
    output logic [CNT_W-1:0] o_num_dup,
    output logic             o_fifo_empty,
    output logic             o_fifo_full
`ifdef QED_UNSUPPORTED_CHECK_EN
    ,
    output logic             o_unsupported_op
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      LAST_FREE = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0]      ONE_LEFT  = (AW + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_num_orig;
    logic [CNT_W-1:0] r_num_dup;
    logic             r_qed_ready;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_orig_nxt;
    logic [CNT_W-1:0] w_dup_nxt;
    logic             w_empty_nxt;
    logic             w_ready_nxt;
    logic [31:0]      w_head;
    logic [AW:0]      w_count;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic             w_unsup;
    logic             w_push;
    logic             w_pop;
    logic             w_fill;
    logic             w_req;
    logic             w_drain;

`ifdef QED_UNSUPPORTED_CHECK_EN
    assign w_unsup = i_ena & (r_state == ST_ORIG) & i_qic_valid
                   & ~qed_is_supported(i_qic_instruction[6:0]);
    assign o_unsupported_op = w_unsup;
`else
    assign w_unsup = 1'b0;
`endif

    assign w_push  = i_ena & (r_state == ST_ORIG) & i_qic_valid & ~i_stall & ~w_unsup;
    assign w_pop   = i_ena & (r_state == ST_DUP) & ~i_stall & ~w_fifo_empty;
    assign w_fill  = w_push & (w_count == LAST_FREE);
    assign w_req   = i_ena & (r_state == ST_ORIG) & i_exec_dup_req & ~i_stall
                   & (~w_fifo_empty | w_push);
    assign w_drain = w_pop & (w_count == ONE_LEFT);

    qed_dup_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (~i_ena),
        .i_push  (w_push),
        .i_data  (i_qic_instruction),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_count (w_count)
    );

    // qed_ready is computed from next-cycle values so it lines up with the state it describes.
    always_comb begin
        w_state_nxt = r_state;
        w_orig_nxt  = r_num_orig;
        w_dup_nxt   = r_num_dup;
        if (!i_ena) begin
            w_state_nxt = ST_IDLE;
            w_orig_nxt  = '0;
            w_dup_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: if (!i_stall) w_state_nxt = ST_ORIG;
                ST_ORIG: begin
                    if (w_push && r_num_orig != CNT_MAX) w_orig_nxt = r_num_orig + CNT_ONE;
                    if (w_fill || w_req) w_state_nxt = ST_DUP;
                end
                ST_DUP: begin
                    if (w_pop && r_num_dup != CNT_MAX) w_dup_nxt = r_num_dup + CNT_ONE;
                    if (w_drain) w_state_nxt = ST_ORIG;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
        w_empty_nxt = ~i_ena | (w_fifo_empty & ~w_push) | w_drain;
        w_ready_nxt = (w_state_nxt == ST_ORIG) & w_empty_nxt & (w_orig_nxt == w_dup_nxt)
                    & (w_orig_nxt != '0) & (w_orig_nxt != CNT_MAX) & (w_dup_nxt != CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_num_orig  <= '0;
            r_num_dup   <= '0;
            r_qed_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_num_orig  <= w_orig_nxt;
            r_num_dup   <= w_dup_nxt;
            r_qed_ready <= w_ready_nxt;
        end
    end

    assign o_exec_dup        = (r_state == ST_DUP);
    assign o_qed_ready       = r_qed_ready;
    assign o_num_orig        = r_num_orig;
    assign o_num_dup         = r_num_dup;
    assign o_fifo_empty      = w_fifo_empty;
    assign o_fifo_full       = w_fifo_full;
    assign o_qed_instruction = w_fifo_empty ? 32'h0 : qed_transform(w_head);

endmodule

// File: tb/tb_qed_dup_scheduler.sv
// Self-checking bench for qed_dup_scheduler: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the scheduling rules.
`timescale 1ns/1ps
module tb_qed_dup_scheduler;

   localparam int DEPTH   = 4;
   localparam int CNT_W   = 6;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int M_IDLE  = 0;
   localparam int M_ORIG  = 1;
   localparam int M_DUP   = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             ena;
   logic             stall;
   logic             qicValid;
   logic [31:0]      qicInstr;
   logic             dupReq;
   logic [31:0]      qedInstr;
   logic             execDup;
   logic             qedReady;
   logic [CNT_W-1:0] numOrig;
   logic [CNT_W-1:0] numDup;
   logic             fifoEmpty;
   logic             fifoFull;
`ifdef QED_UNSUPPORTED_CHECK_EN
   logic             unsupportedOp;
`endif

   int nCompared   = 0;
   int nMismatched = 0;

   int          mMode;
   int          mOrig;
   int          mDup;
   logic [31:0] mQueue[$];

   always #5 clk = ~clk;

   qed_dup_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .i_ena             (ena),
      .i_stall           (stall),
      .i_qic_valid       (qicValid),
      .i_qic_instruction (qicInstr),
      .i_exec_dup_req    (dupReq),
      .o_qed_instruction (qedInstr),
      .o_exec_dup        (execDup),
      .o_qed_ready       (qedReady),
      .o_num_orig        (numOrig),
      .o_num_dup         (numDup),
      .o_fifo_empty      (fifoEmpty),
      .o_fifo_full       (fifoFull)
`ifdef QED_UNSUPPORTED_CHECK_EN
      ,
      .o_unsupported_op  (unsupportedOp)
`endif
   );

   // Opcode classes decide which register fields are renamed; a nonzero field gains +16.
   function automatic logic [31:0] refTransform(input logic [31:0] ins);
      int   op;
      int   rd;
      int   rs1;
      int   rs2;
      logic [31:0] out;
      op  = int'(ins[6:0]);
      rd  = int'((ins >> 7) & 32'h1F);
      rs1 = int'((ins >> 15) & 32'h1F);
      rs2 = int'((ins >> 20) & 32'h1F);
      out = ins;
      if (op == 'h33 || op == 'h3B) begin
         if (rd  != 0 && rd  < 16) out = out + (32'd16 << 7);
         if (rs1 != 0 && rs1 < 16) out = out + (32'd16 << 15);
         if (rs2 != 0 && rs2 < 16) out = out + (32'd16 << 20);
      end else if (op == 'h13 || op == 'h1B || op == 'h03) begin
         if (rd  != 0 && rd  < 16) out = out + (32'd16 << 7);
         if (rs1 != 0 && rs1 < 16) out = out + (32'd16 << 15);
      end else if (op == 'h23) begin
         if (rs1 != 0 && rs1 < 16) out = out + (32'd16 << 15);
         if (rs2 != 0 && rs2 < 16) out = out + (32'd16 << 20);
      end else if (op == 'h37 || op == 'h17) begin
         if (rd  != 0 && rd  < 16) out = out + (32'd16 << 7);
      end
      return out;
   endfunction

   function automatic bit isSupported(input logic [31:0] ins);
      int op;
      op = int'(ins[6:0]);
      return (op == 'h33 || op == 'h3B || op == 'h13 || op == 'h1B || op == 'h03 ||
              op == 'h23 || op == 'h37 || op == 'h17);
   endfunction

   function automatic logic [31:0] randInstr(input bit allowUnsup);
      logic [6:0]  ops [10];
      logic [31:0] r;
      ops = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h63};
      r = $urandom();
      r[6:0] = ops[$urandom_range(0, allowUnsup ? 9 : 7)];
      if ($urandom_range(0, 3) == 0) r[11:7] = 5'd0;
      if ($urandom_range(0, 3) == 0) r[19:15] = 5'd0;
      return r;
   endfunction

   function automatic bit refReady();
      return (mMode == M_ORIG) && (mQueue.size() == 0) && (mOrig == mDup) && (mOrig != 0)
             && (mOrig < CNT_MAX) && (mDup < CNT_MAX);
   endfunction

   // Advances the reference model by one clock edge using the inputs currently driven.
   task automatic modelStep();
      bit accepted;
`ifdef QED_UNSUPPORTED_CHECK_EN
      accepted = isSupported(qicInstr);
`else
      accepted = 1'b1;
`endif
      if (!ena) begin
         mMode = M_IDLE;
         mQueue.delete();
         mOrig = 0;
         mDup  = 0;
      end else if (stall) begin
         mMode = mMode;
      end else if (mMode == M_IDLE) begin
         mMode = M_ORIG;
      end else if (mMode == M_ORIG) begin
         if (qicValid && accepted) begin
            mQueue.push_back(qicInstr);
            if (mOrig < CNT_MAX) mOrig++;
         end
         if (mQueue.size() == DEPTH || (dupReq && mQueue.size() > 0)) mMode = M_DUP;
      end else if (mQueue.size() > 0) begin
         void'(mQueue.pop_front());
         if (mDup < CNT_MAX) mDup++;
         if (mQueue.size() == 0) mMode = M_ORIG;
      end
   endtask

   // One clock edge for both DUT and model; returns 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ena = 1'b0; stall = 1'b0; qicValid = 1'b0; qicInstr = '0; dupReq = 1'b0;
      mMode = M_IDLE; mQueue.delete(); mOrig = 0; mDup = 0;
      #12;
      nCompared++;
      if ({qedInstr, execDup, qedReady, numOrig, numDup, fifoEmpty, fifoFull} !==
          {32'h0, 1'b0, 1'b0, CNT_W'(0), CNT_W'(0), 1'b1, 1'b0}) begin
         nMismatched++;
         $display("[TB] FAIL reset_values: got instr=%h dup=%b rdy=%b orig=%0d dup=%0d empty=%b full=%b, expected 0/0/0/0/0/1/0",
                  qedInstr, execDup, qedReady, numOrig, numDup, fifoEmpty, fifoFull);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic_replay();
      ena = 1'b1;
      step();
      qicValid = 1'b1; qicInstr = 32'h002081B3;
      repeat (3) step();
      qicValid = 1'b0;
      nCompared++;
      if (numOrig !== CNT_W'(3)) begin
         nMismatched++; $display("[TB] FAIL basic_num_orig: got %0d, expected 3", numOrig);
      end
      nCompared++;
      if (qedInstr !== 32'h012889B3) begin
         nMismatched++; $display("[TB] FAIL basic_head: got %h, expected 012889b3", qedInstr);
      end
      dupReq = 1'b1;
      step();
      dupReq = 1'b0;
      nCompared++;
      if (execDup !== 1'b1) begin
         nMismatched++; $display("[TB] FAIL basic_exec_dup: got %b, expected 1", execDup);
      end
      for (int i = 0; i < 3; i++) begin
         nCompared++;
         if (qedInstr !== 32'h012889B3) begin
            nMismatched++; $display("[TB] FAIL basic_replay_%0d: got %h, expected 012889b3", i, qedInstr);
         end
         step();
      end
      nCompared++;
      if ({execDup, numDup, fifoEmpty, qedReady} !== {1'b0, CNT_W'(3), 1'b1, 1'b1}) begin
         nMismatched++;
         $display("[TB] FAIL basic_balanced: got dup=%b num_dup=%0d empty=%b ready=%b, expected 0/3/1/1",
                  execDup, numDup, fifoEmpty, qedReady);
      end
   endtask

   task automatic test_fill();
      logic [31:0] expQ[$];
      qicValid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         qicInstr = randInstr(1'b0);
         expQ.push_back(qicInstr);
         nCompared++;
         if ({execDup, fifoFull} !== 2'b00) begin
            nMismatched++; $display("[TB] FAIL fill_early_%0d: got dup=%b full=%b, expected 0/0", i, execDup, fifoFull);
         end
         step();
      end
      qicValid = 1'b0;
      nCompared++;
      if ({execDup, fifoFull} !== 2'b11) begin
         nMismatched++; $display("[TB] FAIL fill_full: got dup=%b full=%b, expected 1/1", execDup, fifoFull);
      end
      for (int i = 0; i < DEPTH; i++) begin
         nCompared++;
         if (qedInstr !== refTransform(expQ[i])) begin
            nMismatched++; $display("[TB] FAIL fill_order_%0d: got %h, expected %h", i, qedInstr, refTransform(expQ[i]));
         end
         step();
      end
      nCompared++;
      if ({fifoEmpty, fifoFull, execDup, numOrig, numDup} !== {1'b1, 1'b0, 1'b0, CNT_W'(7), CNT_W'(7)}) begin
         nMismatched++;
         $display("[TB] FAIL fill_drained: got empty=%b full=%b dup=%b orig=%0d dup=%0d, expected 1/0/0/7/7",
                  fifoEmpty, fifoFull, execDup, numOrig, numDup);
      end
   endtask

   task automatic test_stall();
      logic [31:0] expQ[$];
      logic [CNT_W-1:0] dupBefore;
      qicValid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         qicInstr = randInstr(1'b0);
         expQ.push_back(qicInstr);
         step();
      end
      qicValid = 1'b0;
      step();
      dupBefore = numDup;
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         nCompared++;
         if ({qedInstr, numDup, execDup} !== {refTransform(expQ[1]), CNT_W'(dupBefore), 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL stall_frozen_%0d: got head=%h num_dup=%0d dup=%b, expected %h/%0d/1",
                     i, qedInstr, numDup, execDup, refTransform(expQ[1]), dupBefore);
         end
      end
      stall = 1'b0;
      for (int i = 1; i < DEPTH; i++) begin
         nCompared++;
         if (qedInstr !== refTransform(expQ[i])) begin
            nMismatched++; $display("[TB] FAIL stall_resume_%0d: got %h, expected %h", i, qedInstr, refTransform(expQ[i]));
         end
         step();
      end
      nCompared++;
      if (numDup !== CNT_W'(mDup) || mDup != 11) begin
         nMismatched++; $display("[TB] FAIL stall_num_dup: got %0d, expected 11", numDup);
      end
   endtask

   task automatic test_ena_drop();
      qicValid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         qicInstr = randInstr(1'b0);
         dupReq = (i == 2);
         step();
      end
      qicValid = 1'b0; dupReq = 1'b0;
      step();
      nCompared++;
      if ({execDup, fifoEmpty} !== 2'b10) begin
         nMismatched++; $display("[TB] FAIL drop_pre: got dup=%b empty=%b, expected 1/0", execDup, fifoEmpty);
      end
      ena = 1'b0;
      step();
      nCompared++;
      if ({execDup, fifoEmpty, numOrig, numDup, qedReady} !== {1'b0, 1'b1, CNT_W'(0), CNT_W'(0), 1'b0}) begin
         nMismatched++;
         $display("[TB] FAIL drop_idle: got dup=%b empty=%b orig=%0d dup=%0d rdy=%b, expected 0/1/0/0/0",
                  execDup, fifoEmpty, numOrig, numDup, qedReady);
      end
      ena = 1'b1;
      step();
   endtask

   task automatic test_async_reset();
      qicValid = 1'b1;
      repeat (2) begin
         qicInstr = randInstr(1'b0);
         step();
      end
      qicValid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      nCompared++;
      if ({qedInstr, execDup, qedReady, numOrig, numDup, fifoEmpty, fifoFull} !==
          {32'h0, 1'b0, 1'b0, CNT_W'(0), CNT_W'(0), 1'b1, 1'b0}) begin
         nMismatched++;
         $display("[TB] FAIL async_reset: got instr=%h dup=%b rdy=%b orig=%0d dup=%0d empty=%b full=%b, expected 0/0/0/0/0/1/0",
                  qedInstr, execDup, qedReady, numOrig, numDup, fifoEmpty, fifoFull);
      end
      #2;
      rst_n = 1'b1;
      mMode = M_IDLE; mQueue.delete(); mOrig = 0; mDup = 0;
      step();
   endtask

`ifdef QED_UNSUPPORTED_CHECK_EN
   task automatic test_unsupported();
      logic [CNT_W-1:0] origBefore;
      origBefore = numOrig;
      qicValid = 1'b1; qicInstr = 32'h0000006F;
      #1;
      nCompared++;
      if (unsupportedOp !== 1'b1) begin
         nMismatched++; $display("[TB] FAIL unsup_flag: got %b, expected 1", unsupportedOp);
      end
      step();
      qicValid = 1'b0;
      nCompared++;
      if ({numOrig, fifoEmpty} !== {origBefore, 1'b1}) begin
         nMismatched++; $display("[TB] FAIL unsup_not_pushed: got orig=%0d empty=%b, expected %0d/1", numOrig, fifoEmpty, origBefore);
      end
   endtask
`endif

   task automatic test_random();
      logic [31:0] expInstr;
      for (int c = 0; c < 700; c++) begin
         ena      = (c >= 300) ? 1'b1 : ($urandom_range(0, 49) != 0);
         stall    = ($urandom_range(0, 3) == 0);
         qicValid = $urandom_range(0, 1);
         qicInstr = randInstr(1'b1);
         dupReq   = ($urandom_range(0, 5) == 0);
`ifdef QED_UNSUPPORTED_CHECK_EN
         #1;
         nCompared++;
         if (unsupportedOp !== (ena && mMode == M_ORIG && qicValid && !isSupported(qicInstr))) begin
            nMismatched++; $display("[TB] FAIL rand_unsup_%0d: got %b", c, unsupportedOp);
         end
`endif
         step();
         expInstr = (mQueue.size() > 0) ? refTransform(mQueue[0]) : 32'h0;
         nCompared++;
         if ({execDup, fifoEmpty, fifoFull, qedReady} !==
             {mMode == M_DUP, mQueue.size() == 0, mQueue.size() == DEPTH, refReady()}) begin
            nMismatched++;
            $display("[TB] FAIL rand_flags_%0d: got dup/empty/full/rdy=%b%b%b%b, expected %b%b%b%b", c,
                     execDup, fifoEmpty, fifoFull, qedReady,
                     mMode == M_DUP, mQueue.size() == 0, mQueue.size() == DEPTH, refReady());
         end
         nCompared++;
         if ({numOrig, numDup} !== {CNT_W'(mOrig), CNT_W'(mDup)}) begin
            nMismatched++; $display("[TB] FAIL rand_counts_%0d: got %0d/%0d, expected %0d/%0d", c, numOrig, numDup, mOrig, mDup);
         end
         nCompared++;
         if (qedInstr !== expInstr) begin
            nMismatched++; $display("[TB] FAIL rand_instr_%0d: got %h, expected %h", c, qedInstr, expInstr);
         end
      end
      nCompared++;
      if (numOrig !== CNT_W'(CNT_MAX)) begin
         nMismatched++; $display("[TB] FAIL rand_saturation: got %0d, expected %0d", numOrig, CNT_MAX);
      end
   endtask

   // Hard bound on simulation time in case anything stops the sequence from advancing.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Runs every scenario in order and reports the totals.
   initial begin
      test_reset();
      test_basic_replay();
      test_fill();
      test_stall();
      test_ena_drop();
      test_async_reset();
`ifdef QED_UNSUPPORTED_CHECK_EN
      test_unsupported();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
